sound_event_scheduler: RTL
==========================

// Module: sound_event_scheduler
// PURPOSE
//  Shares the single tone generator between the game's sound-event sources
//  (lose, win, scored, ball collision pulses from the game controller / hit unit).
//  Latches one-cycle event pulses, arbitrates by fixed priority, and plays a
//  4-note melody per event, timed in video frames (startOfFrame).
//  Drives tone_code / sound_en into the tone generator.
// PARAMETERS
//  NUM_REQ      4  number of event sources (id 0 = highest priority)
//  NOTE_FRAMES  8  frames each note sounds (>=1)
//  GAP_FRAMES   2  silent frames between notes (0 = no gap state)
// PORTS
//  clk           in   1  system clock
//  reset         in   1  async, active-high; clears all state
//  startOfFrame  in   1  one-cycle pulse per video frame; sole timing tick
//  event_req     in   4  one-cycle pulses: [0]=lose [1]=win [2]=scored [3]=collision
//  mute          in   1  level; sync flush of pending and current play
//  tone_code     out  4  note index to tone generator (valid when sound_en=1)
//  sound_en      out  1  tone generator enable
//  busy          out  1  high in PLAY or GAP
//  active_id     out  2  id of event being played (valid when busy)
//  done_pulse    out  1  one cycle after a melody's last note completes
// BEHAVIOUR
//  Reset values: tone_code=0, sound_en=0, busy=0, active_id=0, done_pulse=0,
//   pending=0, state=IDLE, note_idx=0, frame_cnt=0.
//  pending[NUM_REQ-1:0]: bit i set the cycle after event_req[i]=1; repeated
//   requests while set merge (no counting). Clear of a granted bit and a new
//   request for the same bit in the same cycle: set wins (replays later).
//  Melody ROM (note0..3): lose 8,6,4,1 / win 1,4,6,8 / scored 5,9 / 5,9 /
//   collision 3,3,3,3. All codes nonzero.
//  FSM states: IDLE, PLAY, GAP.
//  IDLE: if pending!=0 and !mute -> next cycle PLAY with active_id = lowest set
//   index, that pending bit cleared, note_idx=0, frame_cnt=0,
//   tone_code=ROM[id][0], sound_en=1. Latency request->sound_en: 2 cycles.
//  PLAY: on each startOfFrame frame_cnt++. On startOfFrame with
//   frame_cnt==NOTE_FRAMES-1:
//    - note_idx==3 -> IDLE, sound_en=0, done_pulse=1 for one cycle.
//    - else GAP_FRAMES>0 -> GAP, sound_en=0, frame_cnt=0.
//    - else note_idx++, tone_code=next note, frame_cnt=0, stay PLAY.
//  GAP: on startOfFrame frame_cnt++; at frame_cnt==GAP_FRAMES-1 -> PLAY,
//   note_idx++, tone_code=ROM[id][note_idx+1], sound_en=1, frame_cnt=0.
//  No preemption: a higher-priority request during play waits in pending;
//   served first at the next IDLE.
//  Simultaneous requests: all latched; served in id order, back-to-back
//   (one IDLE cycle between melodies).
//  mute=1: next cycle pending=0, state=IDLE, sound_en=0, busy=0; no done_pulse;
//   event_req ignored while mute=1.
//  startOfFrame absent: counters hold, output holds indefinitely.
//  Counters sized $clog2(max(NOTE_FRAMES,GAP_FRAMES)+1); never wrap past limit.
//  Reset asserted mid-melody: all outputs to reset values immediately (async).
// TESTING
//  1 event_req=4'b0100 one cycle, SOF every 10 clk -> sound_en high 2 clk later,
//    tone 5,9,5,9 each 8 frames, 2-frame gaps, done_pulse after 38 frames.
//  2 event_req=4'b1011 same cycle -> melodies played lose, win, collision in order;
//    3 done_pulses; pending=0 at end.
//  3 collision playing, lose pulse at note 1 -> collision completes unchanged, then lose 8,6,4,1.
//  4 win pulsed 3 times during own playback -> exactly one replay after current.
//  5 mute high mid-note 2 with scored pending -> next cycle sound_en=0, busy=0,
//    pending=0, no done_pulse; req during mute ignored.
//  6 reset high mid-GAP -> all outputs 0 same cycle; after release a new request plays from note 0.

Source files
------------

// File: rtl/sound_event_scheduler.sv
// Shares one tone generator between game sound events: latches event pulses,
// grants by fixed priority (id 0 first) and plays a 4-note melody timed in video frames.
//
// state  | meaning
// IDLE   | silent, waiting for a pending event
// PLAY   | note sounding, counting NOTE_FRAMES frames
// GAP    | silent gap between notes, counting GAP_FRAMES frames
module sound_event_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int NOTE_FRAMES = 8,
    parameter int GAP_FRAMES  = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         startOfFrame,
    input  logic [NUM_REQ-1:0]                           event_req,
    input  logic                                         mute,
    output logic [3:0]                                   tone_code,
    output logic                                         sound_en,
    output logic                                         busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] active_id,
    output logic                                         done_pulse
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MAXF  = (NOTE_FRAMES > GAP_FRAMES) ? NOTE_FRAMES : GAP_FRAMES;
    localparam int CNT_W = $clog2(MAXF + 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_pending;
    logic [1:0]          r_note_idx;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [3:0]          r_tone;
    logic                r_sound_en;
    logic                r_busy;
    logic [ID_W-1:0]     r_active_id;
    logic                r_done;

    logic [ID_W-1:0]     w_grant_id;
    logic [NUM_REQ-1:0]  w_grant_hot;
    logic [NUM_REQ-1:0]  w_clear;
    logic                w_grant;

    // Melody ROM, note 0 in the low nibble.
    function automatic logic [3:0] rom_note(input logic [ID_W-1:0] id, input logic [1:0] idx);
        logic [15:0] row;
        case (int'(id))
            0:       row = 16'h1468;
            1:       row = 16'h8641;
            2:       row = 16'h9595;
            default: row = 16'h3333;
        endcase
        return row[{idx, 2'b00} +: 4];
    endfunction

    always_comb begin
        w_grant_id  = '0;
        w_grant_hot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grant_id  = ID_W'(i);
                w_grant_hot = NUM_REQ'(1) << i;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && (r_pending != '0) && !mute;
    assign w_clear = w_grant ? w_grant_hot : '0;

    // A new request on the bit being cleared wins, so the event replays later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pending <= '0;
        else if (mute)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clear) | event_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_note_idx  <= '0;
            r_frame_cnt <= '0;
            r_tone      <= '0;
            r_sound_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_active_id <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (mute) begin
                r_state    <= S_IDLE;
                r_sound_en <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_grant) begin
                            r_state     <= S_PLAY;
                            r_active_id <= w_grant_id;
                            r_note_idx  <= '0;
                            r_frame_cnt <= '0;
                            r_tone      <= rom_note(w_grant_id, 2'd0);
                            r_sound_en  <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (startOfFrame) begin
                            if (r_frame_cnt == CNT_W'(NOTE_FRAMES - 1)) begin
                                r_frame_cnt <= '0;
                                if (r_note_idx == 2'd3) begin
                                    r_state    <= S_IDLE;
                                    r_sound_en <= 1'b0;
                                    r_busy     <= 1'b0;
                                    r_done     <= 1'b1;
                                end else if (GAP_FRAMES > 0) begin
                                    r_state    <= S_GAP;
                                    r_sound_en <= 1'b0;
                                end else begin
                                    r_note_idx <= r_note_idx + 2'd1;
                                    r_tone     <= rom_note(r_active_id, r_note_idx + 2'd1);
                                end
                            end else begin
                                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_GAP: begin
                        if (startOfFrame) begin
                            if (r_frame_cnt == CNT_W'(GAP_FRAMES - 1)) begin
                                r_state     <= S_PLAY;
                                r_frame_cnt <= '0;
                                r_note_idx  <= r_note_idx + 2'd1;
                                r_tone      <= rom_note(r_active_id, r_note_idx + 2'd1);
                                r_sound_en  <= 1'b1;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tone_code  = r_tone;
    assign sound_en   = r_sound_en;
    assign busy       = r_busy;
    assign active_id  = r_active_id;
    assign done_pulse = r_done;

endmodule
